// File: rtl/pulse_scheduler.sv
// Round-robin arbiter in front of one delayed-pulse generator: grant, DELAY cycles, WIDTH-cycle pulse, done strobe.
// Latency: grant one edge after req is seen; all outputs registered; requests are ignored while a service is in flight.
module pulse_scheduler #(
    parameter int N  = 4,
    parameter int CW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] delay_cfg,
    input  logic [CW-1:0] width_cfg,
    output logic [N-1:0]  grant,
    output logic          signal,
    output logic          busy,
    output logic [N-1:0]  done
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_PULSE,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_width;
    logic [IW-1:0] r_rr_ptr;
    logic [IW-1:0] r_idx;

    logic          w_found;
    logic [IW-1:0] w_win;
    logic [IW-1:0] w_idx;
    logic [N-1:0]  w_win_oh;
    logic [CW-1:0] w_width;
    logic [IW-1:0] w_rr_next;

    // First requester at or after the round-robin pointer, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 0; i < N; i++) begin
            w_idx = IW'((int'(r_rr_ptr) + i) % N);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_win_oh  = N'(1) << w_win;
    assign w_width   = (width_cfg == '0) ? CW'(1) : width_cfg;
    assign w_rr_next = (r_idx == IW'(N - 1)) ? '0 : r_idx + 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_width  <= '0;
            r_rr_ptr <= '0;
            r_idx    <= '0;
            grant    <= '0;
            signal   <= 1'b0;
            busy     <= 1'b0;
            done     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= '0;
                    if (w_found) begin
                        grant   <= w_win_oh;
                        r_idx   <= w_win;
                        r_width <= w_width;
                        busy    <= 1'b1;
                        if (delay_cfg == '0) begin
                            r_state <= S_PULSE;
                            r_cnt   <= w_width;
                            signal  <= 1'b1;
                        end else begin
                            r_state <= S_DELAY;
                            r_cnt   <= delay_cfg;
                        end
                    end
                end
                S_DELAY: begin
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_PULSE;
                        r_cnt   <= r_width;
                        signal  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_PULSE: begin
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_DONE;
                        r_cnt   <= '0;
                        signal  <= 1'b0;
                        done    <= grant;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    r_state  <= S_IDLE;
                    grant    <= '0;
                    done     <= '0;
                    busy     <= 1'b0;
                    r_rr_ptr <= w_rr_next;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_scheduler.sv
// Bench for pulse_scheduler: table of single services plus round-robin, config-isolation and async-reset sequences.
module tb_pulse_scheduler;

    localparam int N  = 4;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req = '0;
    logic [CW-1:0] delay_cfg = '0;
    logic [CW-1:0] width_cfg = '0;
    logic [N-1:0]  grant;
    logic          signal;
    logic          busy;
    logic [N-1:0]  done;

    pulse_scheduler #(.N(N), .CW(CW)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .delay_cfg (delay_cfg),
        .width_cfg (width_cfg),
        .grant     (grant),
        .signal    (signal),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [N-1:0] g;
        int           d;
        int           w;
    } exp_t;

    typedef struct {
        logic [N-1:0] req;
        int           d;
        int           w;
        logic [N-1:0] eg;
        int           ew;
    } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   n_done = 0;

    task automatic chk(input bit ok, input string name, input int act, input int req_v);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req_v);
        end
    endtask

    // Service monitor: measures grant->signal delay, pulse width and done alignment.
    int           cyc = 0;
    int           g_cyc = 0, s_rise = 0, s_fall = 0, last_done = -100;
    logic [N-1:0] pg = '0;
    logic         ps = 1'b0;
    bit           chk_idle = 1'b0;

    always @(negedge clock) begin
        exp_t e;
        cyc++;
        if (reset) begin
            pg = '0;
            ps = 1'b0;
            chk_idle = 1'b0;
            last_done = -100;
        end else begin
            if (chk_idle) begin
                chk_idle = 1'b0;
                chk(!busy && grant == '0 && done == '0, "idle_after_done",
                    int'({busy, grant, done}), 0);
            end
            if (pg == '0 && grant != '0) begin
                g_cyc = cyc;
                chk(cyc - last_done >= 2, "idle_gap", cyc - last_done, 2);
                chk(busy == 1'b1, "busy_at_grant", int'(busy), 1);
            end
            if (!ps && signal) s_rise = cyc;
            if (ps && !signal) s_fall = cyc;
            if (done != '0) begin
                if (sb.size() == 0) begin
                    chk(1'b0, "unexpected_done", int'(done), 0);
                end else begin
                    e = sb.pop_front();
                    chk(grant == e.g, "grant", int'(grant), int'(e.g));
                    chk(done == e.g, "done_onehot", int'(done), int'(e.g));
                    chk(s_rise - g_cyc == e.d, "delay", s_rise - g_cyc, e.d);
                    chk(s_fall - s_rise == e.w, "width", s_fall - s_rise, e.w);
                    chk(s_fall == cyc, "done_align", cyc - s_fall, 0);
                end
                n_done++;
                last_done = cyc;
                chk_idle = 1'b1;
            end
            pg = grant;
            ps = signal;
        end
    end

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (grant != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_signal(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (signal) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_reset();
        @(posedge clock);
        #1 reset = 1'b1;
        repeat (2) @(negedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    vec_t tbl[6];
    bit   ok;
    int   base;

    initial begin
        // Each row assumes the round-robin pointer left by the previous row.
        tbl[0] = '{4'b0001, 2,  3,  4'b0001, 3};
        tbl[1] = '{4'b0010, 0,  0,  4'b0010, 1};
        tbl[2] = '{4'b0101, 1,  2,  4'b0100, 2};
        tbl[3] = '{4'b0011, 0,  4,  4'b0001, 4};
        tbl[4] = '{4'b1001, 4,  1,  4'b1000, 1};
        tbl[5] = '{4'b0110, 15, 15, 4'b0010, 15};

        repeat (2) @(negedge clock);
        chk(grant == '0 && signal == 1'b0 && busy == 1'b0 && done == '0, "reset_outputs",
            int'({grant, signal, busy, done}), 0);
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (2) @(negedge clock);
        chk(grant == '0 && !signal && !busy && done == '0, "idle_no_req",
            int'({grant, signal, busy, done}), 0);

        for (int v = 0; v < 6; v++) begin
            @(posedge clock);
            #1;
            req       = tbl[v].req;
            delay_cfg = CW'(tbl[v].d);
            width_cfg = CW'(tbl[v].w);
            sb.push_back('{tbl[v].eg, tbl[v].d, tbl[v].ew});
            wait_grant(ok);
            chk(ok, "timeout_grant", 0, 1);
            req = '0;
            wait_idle(ok);
            chk(ok, "timeout_idle", 0, 1);
        end

        // Round robin with all requesters held.
        pulse_reset();
        base = n_done;
        for (int i = 0; i < 5; i++) sb.push_back('{N'(1) << (i % N), 1, 1});
        delay_cfg = CW'(1);
        width_cfg = CW'(1);
        req = 4'b1111;
        for (int i = 0; i < 300 && n_done < base + 4; i++) begin
            @(negedge clock);
            #1;
        end
        chk(n_done == base + 4, "rr_progress", n_done - base, 4);
        wait_grant(ok);
        chk(ok, "timeout_rr_grant", 0, 1);
        req = '0;
        wait_idle(ok);
        chk(ok, "timeout_rr_idle", 0, 1);

        // Config changed during DELAY must not affect the service in flight.
        @(posedge clock);
        #1;
        req = 4'b0001;
        delay_cfg = CW'(3);
        width_cfg = CW'(2);
        sb.push_back('{4'b0001, 3, 2});
        wait_grant(ok);
        chk(ok, "timeout_cfg_grant", 0, 1);
        req = '0;
        delay_cfg = CW'(0);
        width_cfg = CW'(9);
        wait_idle(ok);
        chk(ok, "timeout_cfg_idle", 0, 1);

        // Move the pointer to 3 so the post-reset scan order is observable.
        @(posedge clock);
        #1;
        req = 4'b0100;
        delay_cfg = '0;
        width_cfg = '0;
        sb.push_back('{4'b0100, 0, 1});
        wait_grant(ok);
        chk(ok, "timeout_ptr_grant", 0, 1);
        req = '0;
        wait_idle(ok);
        chk(ok, "timeout_ptr_idle", 0, 1);

        // Async reset while the pulse is high.
        @(posedge clock);
        #1;
        req = 4'b1000;
        delay_cfg = CW'(2);
        width_cfg = CW'(5);
        wait_grant(ok);
        chk(ok, "timeout_rst_grant", 0, 1);
        chk(grant == 4'b1000, "rst_pre_grant", int'(grant), 8);
        req = '0;
        wait_signal(ok);
        chk(ok, "timeout_rst_signal", 0, 1);
        @(posedge clock);
        #3 reset = 1'b1;
        #1;
        chk(signal == 1'b0, "async_signal", int'(signal), 0);
        chk(grant == '0, "async_grant", int'(grant), 0);
        chk(busy == 1'b0, "async_busy", int'(busy), 0);
        chk(done == '0, "async_done", int'(done), 0);
        sb.delete();
        repeat (2) @(negedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        req = 4'b1001;
        delay_cfg = CW'(1);
        width_cfg = CW'(2);
        sb.push_back('{4'b0001, 1, 2});
        wait_grant(ok);
        chk(ok, "timeout_post_rst_grant", 0, 1);
        chk(grant == 4'b0001, "post_rst_scan", int'(grant), 1);
        req = '0;
        wait_idle(ok);
        chk(ok, "timeout_post_rst_idle", 0, 1);

        repeat (3) @(negedge clock);
        chk(sb.size() == 0, "sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
